// File: rtl/mega_alu_wb_pkg.sv
// Shared types and constants for the XMEGA writeback/status stage.
// SREG bit indices, SREG I/O address default and the writeback buffer entry.
package mega_alu_wb_pkg;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam int SREG_T = 6;
    localparam int SREG_I = 7;

    localparam logic [5:0] SREG_IO_ADDR_DEF = 6'h3F;
    localparam logic [7:0] RST_SREG_DEF     = 8'h00;

    typedef struct packed {
        logic        wr_16;
        logic [4:0]  addr;
        logic [15:0] data;
    } wb_entry_t;

    // Pair writes always target the even register; byte writes carry a zero upper byte.
    function automatic wb_entry_t wb_pack(input logic wr_16, input logic [4:0] rd_addr,
                                          input logic [15:0] result);
        wb_entry_t e;
        e.wr_16 = wr_16;
        e.addr  = wr_16 ? {rd_addr[4:1], 1'b0} : rd_addr;
        e.data  = wr_16 ? result : {8'h00, result[7:0]};
        return e;
    endfunction

endpackage

// File: rtl/mega_alu_wb_if.sv
// ALU-retire handshake plus register-file write port of the writeback stage.
// master = upstream ALU / register-file side, slave = the writeback stage.
interface mega_alu_wb_if;

    logic        alu_valid;
    logic        alu_ready;
    logic        alu_wr_en;
    logic        alu_wr_16;
    logic [4:0]  alu_rd_addr;
    logic [15:0] alu_out;
    logic [7:0]  alu_flag_msk;
    logic [7:0]  alu_flags;

    logic        rf_wr_en;
    logic        rf_wr_16;
    logic [4:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        rf_ready;

    modport master (
        output alu_valid, alu_wr_en, alu_wr_16, alu_rd_addr, alu_out, alu_flag_msk, alu_flags,
        output rf_ready,
        input  alu_ready, rf_wr_en, rf_wr_16, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  alu_valid, alu_wr_en, alu_wr_16, alu_rd_addr, alu_out, alu_flag_msk, alu_flags,
        input  rf_ready,
        output alu_ready, rf_wr_en, rf_wr_16, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/mega_wb_fwd.sv
// Operand forwarding from the pending writeback entry (used with MEGA_WB_FWD_EN).
// A hit on the high register of a pair returns the high byte shifted down.
module mega_wb_fwd
    import mega_alu_wb_pkg::*;
(
    input  logic        wb_pending,
    input  wb_entry_t   wb,
    input  logic [4:0]  fwd_addr_1,
    input  logic [4:0]  fwd_addr_2,
    output logic        fwd_hit_1,
    output logic        fwd_hit_2,
    output logic [15:0] fwd_data
);

    logic lo_1, hi_1, lo_2, hi_2;

    assign lo_1 = (fwd_addr_1 == wb.addr);
    assign hi_1 = wb.wr_16 & (fwd_addr_1 == (wb.addr + 5'd1));
    assign lo_2 = (fwd_addr_2 == wb.addr);
    assign hi_2 = wb.wr_16 & (fwd_addr_2 == (wb.addr + 5'd1));

    assign fwd_hit_1 = wb_pending & (lo_1 | hi_1);
    assign fwd_hit_2 = wb_pending & (lo_2 | hi_2);

    // Operand 1 decides the byte lane; operand 2 only when operand 1 misses.
    assign fwd_data = (hi_1 | (~lo_1 & hi_2)) ? {8'h00, wb.data[15:8]} : wb.data;

endmodule

// File: rtl/mega_alu_wb.sv
// XMEGA writeback/status stage: SREG, one-entry register-file write buffer, I-flag shadow.
// Optional operand forwarding is compiled in with `define MEGA_WB_FWD_EN.
module mega_alu_wb
    import mega_alu_wb_pkg::*;
#(
    parameter logic [5:0] SREG_IO_ADDR = SREG_IO_ADDR_DEF,
    parameter logic [7:0] RST_SREG     = RST_SREG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mega_alu_wb_if.slave bus,
    input  logic        io_wr_en,
    input  logic [5:0]  io_addr,
    input  logic [7:0]  io_wdata,
    output logic [7:0]  io_rdata,
    input  logic        reti,
    input  logic        irq_ack,
    output logic [7:0]  sreg,
    output logic        int_en,
    input  logic [4:0]  fwd_addr_1,
    input  logic [4:0]  fwd_addr_2,
    output logic        fwd_hit_1,
    output logic        fwd_hit_2,
    output logic [15:0] fwd_data
);

    logic [7:0] sreg_q, sreg_nxt;
    logic       sei_shadow_q, sei_shadow_nxt;
    logic       int_en_q;
    logic       wb_pending_q;
    wb_entry_t  wb_q;
    logic       accept;
    logic       io_sreg_wr;

    assign bus.alu_ready = ~wb_pending_q | bus.rf_ready;
    assign accept        = bus.alu_valid & bus.alu_ready;
    assign io_sreg_wr    = io_wr_en & (io_addr == SREG_IO_ADDR);

    // Later writes override earlier ones: io < ALU mask < reti < irq_ack.
    always_comb begin
        // NOTE: defaults first so every path assigns each variable and no latch is inferred.
        sreg_nxt       = sreg_q;
        sei_shadow_nxt = sei_shadow_q;
        if (io_sreg_wr) sreg_nxt = io_wdata;
        if (accept)     sreg_nxt = (sreg_nxt & ~bus.alu_flag_msk) | (bus.alu_flags & bus.alu_flag_msk);
        if (reti)       sreg_nxt[SREG_I] = 1'b1;
        if (irq_ack)    sreg_nxt[SREG_I] = 1'b0;
        if (accept)     sei_shadow_nxt = 1'b0;
        if (~sreg_q[SREG_I] & sreg_nxt[SREG_I]) sei_shadow_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is a handful of flops, so it is reset along with wb_pending to keep rf_wr_* at zero.
            sreg_q       <= RST_SREG;
            sei_shadow_q <= 1'b0;
            int_en_q     <= 1'b0;
            wb_pending_q <= 1'b0;
            wb_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sreg_q       <= sreg_nxt;
            sei_shadow_q <= sei_shadow_nxt;
            int_en_q     <= sreg_nxt[SREG_I] & ~sei_shadow_nxt;
            if (accept && bus.alu_wr_en) begin
                wb_pending_q <= 1'b1;
                wb_q         <= wb_pack(bus.alu_wr_16, bus.alu_rd_addr, bus.alu_out);
            end else if (wb_pending_q && bus.rf_ready) begin
                wb_pending_q <= 1'b0;
            end
        end
    end

    assign sreg           = sreg_q;
    assign int_en         = int_en_q;
    assign io_rdata       = (io_addr == SREG_IO_ADDR) ? sreg_q : 8'h00;
    assign bus.rf_wr_en   = wb_pending_q;
    assign bus.rf_wr_16   = wb_q.wr_16;
    assign bus.rf_wr_addr = wb_q.addr;
    assign bus.rf_wr_data = wb_q.data;

`ifdef MEGA_WB_FWD_EN
    mega_wb_fwd u_fwd (
        .wb_pending (wb_pending_q),
        .wb         (wb_q),
        .fwd_addr_1 (fwd_addr_1),
        .fwd_addr_2 (fwd_addr_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_hit_2  (fwd_hit_2),
        .fwd_data   (fwd_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_1, fwd_addr_2};
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data   = 16'h0000;
`endif

endmodule

// File: tb/tb_mega_alu_wb.sv
// Self-checking bench for mega_alu_wb: scoreboard of expected register-file writes
// plus direct checks of SREG, interrupt enable, stall behaviour and the I/O window.
module tb_mega_alu_wb;
    import mega_alu_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_wr_en;
    logic [5:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        reti;
    logic        irq_ack;
    logic [7:0]  sreg;
    logic        int_en;
    logic [4:0]  fwd_addr_1;
    logic [4:0]  fwd_addr_2;
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [15:0] fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    wb_entry_t sb[$];

    mega_alu_wb_if bus ();

    mega_alu_wb dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .io_wr_en   (io_wr_en),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .reti       (reti),
        .irq_ack    (irq_ack),
        .sreg       (sreg),
        .int_en     (int_en),
        .fwd_addr_1 (fwd_addr_1),
        .fwd_addr_2 (fwd_addr_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_hit_2  (fwd_hit_2),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Retire one ALU op; returns just after the accepting edge.
    task automatic alu_op(input logic wr_en, input logic wr16, input logic [4:0] rd,
                          input logic [15:0] result, input logic [7:0] msk, input logic [7:0] flags);
        wb_entry_t e;
        bit        got = 0;
        bus.alu_valid    = 1'b1;
        bus.alu_wr_en    = wr_en;
        bus.alu_wr_16    = wr16;
        bus.alu_rd_addr  = rd;
        bus.alu_out      = result;
        bus.alu_flag_msk = msk;
        bus.alu_flags    = flags;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.alu_ready) got = 1;
            else @(posedge clk);
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        if (wr_en) begin
            e.wr_16 = wr16;
            e.addr  = wr16 ? {rd[4:1], 1'b0} : rd;
            e.data  = wr16 ? result : {8'h00, result[7:0]};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0;
    endtask

    // Scoreboard: every completed register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rf_wr_en && bus.rf_ready) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                check("wb_16",   {31'd0, bus.rf_wr_16},  {31'd0, e.wr_16});
                check("wb_addr", {27'd0, bus.rf_wr_addr}, {27'd0, e.addr});
                check("wb_data", {16'd0, bus.rf_wr_data}, {16'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        io_wr_en = 1'b0; io_addr = 6'h3F; io_wdata = 8'h00;
        reti = 1'b0; irq_ack = 1'b0;
        fwd_addr_1 = 5'd0; fwd_addr_2 = 5'd0;
        bus.alu_valid = 1'b0; bus.alu_wr_en = 1'b0; bus.alu_wr_16 = 1'b0;
        bus.alu_rd_addr = 5'd0; bus.alu_out = 16'h0; bus.alu_flag_msk = 8'h0; bus.alu_flags = 8'h0;
        bus.rf_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle state
        @(negedge clk);
        check("rst_sreg",   {24'd0, sreg}, 32'h00);
        check("rst_wr_en",  {31'd0, bus.rf_wr_en}, 32'd0);
        check("rst_ready",  {31'd0, bus.alu_ready}, 32'd1);
        check("rst_io_rd",  {24'd0, io_rdata}, 32'h00);
        check("rst_int_en", {31'd0, int_en}, 32'd0);

        // ADD r5
        @(posedge clk); #1;
        alu_op(1'b1, 1'b0, 5'd5, 16'h0042, 8'h3F, 8'h02);
        @(negedge clk);
        check("add_wr_en", {31'd0, bus.rf_wr_en}, 32'd1);
        check("add_addr",  {27'd0, bus.rf_wr_addr}, 32'd5);
        check("add_data",  {16'd0, bus.rf_wr_data}, 32'h0042);
        check("add_sreg",  {24'd0, sreg}, 32'h02);
        @(posedge clk); #1;

        // ADIW r25 under 3 cycles of backpressure; a held ALU op must not touch SREG
        bus.rf_ready = 1'b0;
        alu_op(1'b1, 1'b1, 5'd25, 16'h1234, 8'h1F, 8'h01);
        bus.alu_valid = 1'b1; bus.alu_wr_en = 1'b0; bus.alu_flag_msk = 8'hFF; bus.alu_flags = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, bus.alu_ready}, 32'd0);
            check("stall_wr_en", {31'd0, bus.rf_wr_en}, 32'd1);
            check("stall_16",    {31'd0, bus.rf_wr_16}, 32'd1);
            check("stall_addr",  {27'd0, bus.rf_wr_addr}, 32'd24);
            check("stall_data",  {16'd0, bus.rf_wr_data}, 32'h1234);
        end
        check("stall_sreg", {24'd0, sreg}, 32'h01);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        bus.rf_ready  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);

        // Pending pair write r24/r25 = BEEF, forwarding probes
        @(posedge clk); #1;
        bus.rf_ready = 1'b0;
        alu_op(1'b1, 1'b1, 5'd25, 16'hBEEF, 8'h00, 8'h00);
        fwd_addr_1 = 5'd25; fwd_addr_2 = 5'd24;
        @(negedge clk);
`ifdef MEGA_WB_FWD_EN
        check("fwd_hit_1", {31'd0, fwd_hit_1}, 32'd1);
        check("fwd_hit_2", {31'd0, fwd_hit_2}, 32'd1);
        check("fwd_data",  {16'd0, fwd_data}, 32'h00BE);
`else
        check("fwd_hit_1_tied", {31'd0, fwd_hit_1}, 32'd0);
        check("fwd_data_tied",  {16'd0, fwd_data}, 32'h0000);
`endif
        @(posedge clk); #1;
        bus.rf_ready = 1'b1;

        // Back-to-back retires, odd pair address, flags-only op in the stream
        alu_op(1'b1, 1'b0, 5'd31, 16'hABCD, 8'h00, 8'h00);
        alu_op(1'b1, 1'b1, 5'd31, 16'h5678, 8'h00, 8'h00);
        alu_op(1'b0, 1'b0, 5'd3,  16'hFFFF, 8'h01, 8'h01);
        alu_op(1'b1, 1'b0, 5'd0,  16'h00FF, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("b2b_idle",  {31'd0, bus.rf_wr_en}, 32'd0);
        check("b2b_empty", sb.size(), 32'd0);
        check("b2b_sreg",  {24'd0, sreg}, 32'h01);

        // SEI: interrupts held off until the following accept
        @(posedge clk); #1;
        alu_op(1'b0, 1'b0, 5'd0, 16'h0, 8'h80, 8'h80);
        @(negedge clk);
        check("sei_sreg",   {24'd0, sreg}, 32'h81);
        check("sei_int_en", {31'd0, int_en}, 32'd0);
        repeat (2) @(negedge clk);
        check("sei_hold",   {31'd0, int_en}, 32'd0);
        @(posedge clk); #1;
        alu_op(1'b0, 1'b0, 5'd0, 16'h0, 8'h00, 8'h00);
        @(negedge clk);
        check("sei_next_int_en", {31'd0, int_en}, 32'd1);
        @(posedge clk); #1;
        reti = 1'b1; irq_ack = 1'b1;
        @(posedge clk); #1;
        reti = 1'b0; irq_ack = 1'b0;
        @(negedge clk);
        check("ack_reti_sreg",   {24'd0, sreg}, 32'h01);
        check("ack_reti_int_en", {31'd0, int_en}, 32'd0);

        // io write to SREG in the same cycle as a masked ALU update
        @(posedge clk); #1;
        io_wr_en = 1'b1; io_addr = 6'h3F; io_wdata = 8'hA5;
        alu_op(1'b0, 1'b0, 5'd0, 16'h0, 8'h01, 8'h00);
        io_wr_en = 1'b0;
        @(negedge clk);
        check("io_alu_sreg",   {24'd0, sreg}, 32'hA4);
        check("io_rdata_3f",   {24'd0, io_rdata}, 32'hA4);
        check("io_alu_int_en", {31'd0, int_en}, 32'd0);
        @(posedge clk); #1;
        io_wr_en = 1'b1; io_addr = 6'h3E; io_wdata = 8'h00;
        @(posedge clk); #1;
        io_wr_en = 1'b0;
        @(negedge clk);
        check("io_rdata_3e",   {24'd0, io_rdata}, 32'h00);
        check("io_other_sreg", {24'd0, sreg}, 32'hA4);
        @(posedge clk); #1;
        io_addr = 6'h3F;

        // Reset while a write is stalled discards it
        bus.rf_ready = 1'b0;
        alu_op(1'b1, 1'b0, 5'd7, 16'h0011, 8'h00, 8'h00);
        void'(sb.pop_back());
        @(negedge clk);
        check("pre_rst_wr_en", {31'd0, bus.rf_wr_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rf_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);
        check("mid_rst_sreg",  {24'd0, sreg}, 32'h00);
        check("mid_rst_ready", {31'd0, bus.alu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, bus.rf_wr_en}, 32'd0);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
